// File: rtl/expr_unpack_pkg.sv
// Shared constants, field layout tables and FSM encoding for the
// packed-result unpacker (optional parity output: UNPACK_PARITY_EN).
package expr_unpack_pkg;

    localparam int WORD_W     = 90;
    localparam int NUM_FIELDS = 18;
    localparam int RAW_W      = 6;

    // Field layout repeats every 6 fields (30 bits per group).
    localparam logic [2:0] FIELD_W [6] = '{
        3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6
    };
    localparam logic FIELD_SIGNED [6] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Width of the field at position ph within its 6-field group.
    function automatic logic [2:0] field_w(input logic [2:0] ph);
        logic [2:0] w;
        w = 3'd4;
        case (ph)
            3'd0: w = FIELD_W[0];
            3'd1: w = FIELD_W[1];
            3'd2: w = FIELD_W[2];
            3'd3: w = FIELD_W[3];
            3'd4: w = FIELD_W[4];
            3'd5: w = FIELD_W[5];
            default: w = 3'd4;
        endcase
        return w;
    endfunction

    // Signedness of the field at position ph within its group.
    function automatic logic field_signed(input logic [2:0] ph);
        logic s;
        s = 1'b0;
        case (ph)
            3'd0: s = FIELD_SIGNED[0];
            3'd1: s = FIELD_SIGNED[1];
            3'd2: s = FIELD_SIGNED[2];
            3'd3: s = FIELD_SIGNED[3];
            3'd4: s = FIELD_SIGNED[4];
            3'd5: s = FIELD_SIGNED[5];
            default: s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/expr_result_unpacker_field_extend.sv
// Right-aligns the top `width` bits of a 6-bit MSB slice and
// zero- or sign-extends them to OUT_W bits.
module field_extend
    import expr_unpack_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [RAW_W-1:0] raw,
    input  logic [2:0]       width,
    input  logic             is_signed,
    output logic [OUT_W-1:0] result
);

    logic [RAW_W-1:0] aligned;
    logic             ext;

    // Align the field to bit 0 and fill the upper bits.
    always_comb begin
        aligned = raw >> (3'd6 - width);
        ext     = is_signed & raw[RAW_W-1];
        result  = {OUT_W{ext}};
        for (int i = 0; i < RAW_W; i++) begin
            if (3'(i) < width) begin
                result[i] = aligned[i];
            end
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Streams the 18 packed fields of a 90-bit result word, one per
// handshake (optional out_parity output: UNPACK_PARITY_EN).
module expr_result_unpacker
    import expr_unpack_pkg::*;
#(
    parameter int NUM_FIELDS = 18,
    parameter int OUT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_idx,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_signed,
    output logic              out_last
`ifdef UNPACK_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [2:0]        ph_q, ph_d;
    logic [WORD_W-1:0] sr_q, sr_d;

    logic [2:0]        cur_w;
    logic              cur_s;
    logic [RAW_W-1:0]  cur_raw;
    logic [OUT_W-1:0]  ext_data;
    logic              streaming;

    assign cur_w     = field_w(ph_q);
    assign cur_s     = field_signed(ph_q);
    assign cur_raw   = sr_q[WORD_W-1 -: RAW_W];
    assign streaming = (state_q == ST_STREAM);

    field_extend #(
        .OUT_W (OUT_W)
    ) u_ext (
        .raw       (cur_raw),
        .width     (cur_w),
        .is_signed (cur_s),
        .result    (ext_data)
    );

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        in_ready   = !rst && !streaming;
        out_valid  = !rst && streaming;
        out_idx    = idx_q;
        out_data   = rst ? '0 : ext_data;
        out_signed = !rst && cur_s;
        out_last   = !rst && streaming && (idx_q == LAST_IDX);
    end

`ifdef UNPACK_PARITY_EN
    logic [RAW_W-1:0] par_mask;

    // Parity covers only the raw field bits, before extension.
    always_comb begin
        par_mask   = 6'h3F << (3'd6 - cur_w);
        out_parity = !rst && (^(cur_raw & par_mask));
    end
`endif

    // Next-state: capture in IDLE, shift out one field per handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        sr_d    = sr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = in_word;
                    idx_d   = 5'd0;
                    ph_d    = 3'd0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    sr_d = sr_q << cur_w;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 5'd0;
                        ph_d    = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        ph_d  = (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            ph_q    <= 3'd0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            sr_q    <= sr_d;
        end
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed + random checks of expr_result_unpacker against a
// layout-driven field model.
module tb_expr_result_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [7:0]  out_data;
    logic        out_signed;
    logic        out_last;
`ifdef UNPACK_PARITY_EN
    logic        out_parity;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] got [18];

    always #5 clk = ~clk;

    expr_result_unpacker #(
        .NUM_FIELDS (18),
        .OUT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .out_signed (out_signed),
        .out_last   (out_last)
`ifdef UNPACK_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Field i: width 4/5/6 cycling, fields packed MSB-first.
    function automatic void model(input logic [89:0] w, input int i,
                                  output logic [7:0] d, output logic s,
                                  output logic p);
        int start, fw;
        logic [89:0] t;
        logic [7:0] raw, mask;
        start = 0;
        for (int k = 0; k < i; k++) start += 4 + (k % 3);
        fw   = 4 + (i % 3);
        t    = w >> (90 - start - fw);
        mask = 8'((1 << fw) - 1);
        raw  = t[7:0] & mask;
        s    = (i % 6) >= 3;
        p    = ^raw;
        d    = raw;
        if (s && raw[fw-1]) d = raw | ~mask;
    endfunction

    task automatic stream(input logic [89:0] w, input int stall_idx,
                          input int stall_n, input bit rnd,
                          input bit keep, input logic [89:0] nw);
        logic [7:0] ed;
        logic es, ep;
        int n;
        in_word   = w;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        if (keep) in_word = nw;
        else in_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            model(w, i, ed, es, ep);
            n = (i == stall_idx) ? stall_n
              : (rnd ? int'($urandom_range(0, 2)) : 0);
            out_ready = 1'b0;
            for (int k = 0; k < n; k++) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_idx", 32'(out_idx), 32'(i));
                check("stall_data", 32'(out_data), 32'(ed));
                @(negedge clk);
            end
            check("valid", 32'(out_valid), 32'd1);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("idx", 32'(out_idx), 32'(i));
            check("data", 32'(out_data), 32'(ed));
            check("signed", 32'(out_signed), 32'(es));
            check("last", 32'(out_last), 32'(i == 17));
`ifdef UNPACK_PARITY_EN
            check("parity", 32'(out_parity), 32'(ep));
`endif
            got[i]    = out_data;
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [89:0] w, w2;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_signed", 32'(out_signed), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // f0=A, f3=1000, f5=100001
        w = '0;
        w[89:86] = 4'hA;
        w[74:71] = 4'b1000;
        w[65:60] = 6'b100001;
        stream(w, -1, 0, 1'b0, 1'b0, '0);
        check("d29_idx0", 32'(got[0]), 32'h0A);
        check("d29_idx3", 32'(got[3]), 32'hF8);
        check("d29_idx5", 32'(got[5]), 32'hE1);

        // all ones, stalled 3 cycles at idx5
        w = '1;
        stream(w, 5, 3, 1'b0, 1'b0, '0);
        check("ones_u4", 32'(got[0]), 32'h0F);
        check("ones_u5", 32'(got[1]), 32'h1F);
        check("ones_u6", 32'(got[2]), 32'h3F);
        check("ones_s4", 32'(got[3]), 32'hFF);
        check("ones_s6", 32'(got[17]), 32'hFF);

`ifdef UNPACK_PARITY_EN
        w = '0;
        w[85:81] = 5'b10110;
        stream(w, -1, 0, 1'b0, 1'b0, '0);
        w[85:81] = 5'b10010;
        stream(w, -1, 0, 1'b0, 1'b0, '0);
`endif

        // in_valid held through STREAM with a different word offered
        w  = {$urandom, $urandom, $urandom};
        w2 = {$urandom, $urandom, $urandom};
        stream(w, -1, 0, 1'b1, 1'b1, w2);
        stream(w2, -1, 0, 1'b1, 1'b0, '0);

        // random words with random stalls
        for (int r = 0; r < 6; r++) begin
            w = {$urandom, $urandom, $urandom};
            stream(w, -1, 0, 1'b1, 1'b0, '0);
        end

        // abort mid-word at idx9
        w = '1;
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("abort_at9", 32'(out_idx), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("abort_quiet", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
